uart_host_ldr: RTL
==================

// Module: uart_host_ldr
// PURPOSE
// Host-side initiator of the UART RAM-load protocol, the far end of ram_rw. On start_i it emits
// the byte stream that loads a program into remote IRAM/DRAM and releases the CPU, or reads RAM
// back via DATA_RD. It drives a uart_tx byte interface and consumes a uart_rx byte interface.
// Used as a synthesizable loader in a host FPGA and as the stimulus engine in system benches.
// PARAMETERS
// XLEN         32         address/length width
// TIMEOUT_CYC  1000000    max idle cycles between readback bytes before err_o
// PORTS
// clk_i        in   1     clock
// rst_n_i      in   1     async active-low reset
// start_i      in   1     1-cycle request; sampled only in IDLE
// mode_i       in   1     0 = load (write + run), 1 = readback (DATA_RD); sampled with start_i
// base_addr_i  in   XLEN  remote RAM byte address; sampled with start_i
// len_i        in   XLEN  byte count, must be >= 1; sampled with start_i
// src_data_i   in   8     payload byte (load mode)
// src_vld_i    in   1     payload byte valid
// src_rdy_o    out  1     payload byte accepted when src_vld_i && src_rdy_o
// tx_data_o    out  8     byte to uart_tx
// tx_vld_o     out  1     byte valid to uart_tx
// tx_rdy_i     in   1     uart_tx idle/ready
// rx_data_i    in   8     byte from uart_rx
// rx_vld_i     in   1     rx byte valid
// rx_rdy_o     out  1     rx byte consumed when rx_vld_i && rx_rdy_o
// rd_data_o    out  8     readback byte
// rd_vld_o     out  1     1-cycle strobe per readback byte
// busy_o       out  1     high from start acceptance until DONE/ERR
// done_o       out  1     1-cycle pulse on successful completion
// err_o        out  1     1-cycle pulse on bad length or readback timeout
// BEHAVIOUR
// - Reset: all outputs 0, FSM = IDLE, counters 0. Async reset mid-operation aborts immediately;
//   no further bytes are emitted and no done_o/err_o pulse is issued.
// - Tx handshake: a byte is taken when tx_vld_o && tx_rdy_i. tx_vld_o then drops the next cycle.
//   The next byte is not presented until tx_rdy_i has been seen low for >= 1 cycle and is high
//   again, which guards against ready lagging acceptance.
// - Wire sequence, load: 0x2A (CPU_RST), 0x2C (CONF_WR), base_addr[7:0..31:24], (len-1)[7:0..31:24],
//   0x2E (DATA_WR), len payload bytes, 0x2B (CPU_RUN). Multi-byte fields are little-endian.
// - Wire sequence, readback: 0x2A, 0x2C, 8 config bytes as above, 0x2F (DATA_RD). The block then
//   receives exactly len bytes. CPU_RUN is not sent, so the CPU stays held in reset.
// - FSM: IDLE -> CMD_RST -> CMD_CONF -> CONF_B(0..7) -> CMD_DATA -> {PAYLOAD -> CMD_RUN | RDBACK} -> DONE -> IDLE.
//   Any path can go to ERR -> IDLE. DONE and ERR each last 1 cycle.
// - IDLE: a start_i with len_i == 0 goes to ERR (err_o pulse next cycle) and emits no tx byte.
//   busy_o is asserted the cycle after a valid start.
// - PAYLOAD: src_rdy_o = 1 only when no byte is pending for tx. Each accepted src byte is
//   forwarded as the next tx byte. A src stall simply stretches the sequence. Src bytes beyond len
//   are not accepted (src_rdy_o stays 0).
// - Byte counter is XLEN wide and counts down from len; the phase ends when the count reaches 0.
//   The length field is len_i-1, computed modulo 2^XLEN.
// - RDBACK: rx_rdy_o = 1. Each rx byte is copied to rd_data_o, with a rd_vld_o pulse on the
//   following cycle. The timeout counter resets on every byte; it reaching TIMEOUT_CYC -> ERR.
// - rx bytes received outside RDBACK are consumed (rx_rdy_o = 1) and discarded.
// - start_i while busy_o = 1 is ignored. done_o and err_o are never asserted in the same cycle.
// TESTING
// - Load, base=0, len=16, src always valid -> tx = 2A 2C 00 00 00 00 0F 00 00 00 2E <16 B> 2B;
//   one done_o pulse; busy_o low after.
// - Load, base=0x10000004, len=1 -> config bytes 04 00 00 10 00 00 00 00; payload byte; 2B.
// - start_i with len=0 -> err_o pulse 1 cycle later; tx_vld_o never high; busy_o stays 0.
// - Load len=4 with src_vld_i gapped 500 cycles between bytes -> same byte order, no duplicates,
//   no dropped bytes.
// - Readback len=4, model returns AA BB CC DD -> 2F sent, then 4 rd_vld_o pulses AA BB CC DD,
//   then done_o; no 2B sent.
// - Readback len=4, model returns 2 bytes then stops -> err_o after TIMEOUT_CYC cycles.
//   Also: async reset during PAYLOAD -> outputs 0 at once, no done_o/err_o.

Source files
------------

// File: rtl/uart_host_ldr.sv
// Host-side initiator of the UART RAM-load protocol.
// Emits CPU_RST, CONF_WR, 8 config bytes and DATA_WR/DATA_RD. In load mode it
// then forwards the payload and sends CPU_RUN. In readback mode it collects len
// bytes from the rx side, with an inter-byte timeout.
`timescale 1ns/1ps
module uart_host_ldr #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            mode_i,
  input  logic [XLEN-1:0] base_addr_i,
  input  logic [XLEN-1:0] len_i,
  input  logic [7:0]      src_data_i,
  input  logic            src_vld_i,
  output logic            src_rdy_o,
  output logic [7:0]      tx_data_o,
  output logic            tx_vld_o,
  input  logic            tx_rdy_i,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_vld_i,
  output logic            rx_rdy_o,
  output logic [7:0]      rd_data_o,
  output logic            rd_vld_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    CPU_RST  = 8'h2A;
  localparam logic [7:0]    CPU_RUN  = 8'h2B;
  localparam logic [7:0]    CONF_WR  = 8'h2C;
  localparam logic [7:0]    DATA_WR  = 8'h2E;
  localparam logic [7:0]    DATA_RD  = 8'h2F;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD_RST, S_CMD_CONF, S_CONF_B, S_CMD_DATA,
    S_PAYLOAD, S_CMD_RUN, S_RDBACK, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic            mode_q;
  logic [XLEN-1:0] base_q, lenm1_q, cnt_q;
  logic [7:0]      tx_byte_q, tx_ld_byte;
  logic            tx_pend_q, tx_ld;
  logic            tx_armed_q, tx_low_q;
  logic [7:0]      rd_data_q;
  logic            rd_vld_q, rx_rdy_q;
  logic [TW-1:0]   tmo_q;
  logic            tx_acc, src_acc, rx_acc, cnt_zero, rd_take;

  // Config field: base address then (len-1), both little-endian.
  function automatic logic [7:0] cfg_byte(input logic [2:0] idx, input logic [31:0] base,
                                          input logic [31:0] lenm1);
    logic [63:0] cfg;
    cfg = {lenm1, base};
    return cfg[{idx, 3'b000} +: 8];
  endfunction

  assign cnt_zero  = (cnt_q == '0);
  assign tx_vld_o  = tx_pend_q && tx_armed_q;
  assign tx_data_o = tx_byte_q;
  assign tx_acc    = tx_vld_o && tx_rdy_i;
  assign src_rdy_o = (state_q == S_PAYLOAD) && !tx_pend_q && !cnt_zero;
  assign src_acc   = src_vld_i && src_rdy_o;
  assign rx_rdy_o  = rx_rdy_q;
  assign rx_acc    = rx_vld_i && rx_rdy_q;
  assign rd_take   = (state_q == S_RDBACK) && rx_acc && !cnt_zero;
  assign rd_data_o = rd_data_q;
  assign rd_vld_o  = rd_vld_q;
  assign busy_o    = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign done_o    = (state_q == S_DONE);
  assign err_o     = (state_q == S_ERR);

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state and the byte to queue for tx when a state is entered.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_ld      = 1'b0;
    tx_ld_byte = 8'h00;
    case (state_q)
      S_IDLE: if (start_i) begin
        if (len_i == '0) state_d = S_ERR;
        else begin
          state_d = S_CMD_RST; tx_ld = 1'b1; tx_ld_byte = CPU_RST;
        end
      end
      S_CMD_RST: if (tx_acc) begin
        state_d = S_CMD_CONF; tx_ld = 1'b1; tx_ld_byte = CONF_WR;
      end
      S_CMD_CONF: if (tx_acc) begin
        state_d = S_CONF_B; idx_d = 3'd0; tx_ld = 1'b1;
        tx_ld_byte = cfg_byte(3'd0, 32'(base_q), 32'(lenm1_q));
      end
      S_CONF_B: if (tx_acc) begin
        tx_ld = 1'b1;
        if (idx_q == 3'd7) begin
          state_d = S_CMD_DATA; tx_ld_byte = mode_q ? DATA_RD : DATA_WR;
        end else begin
          idx_d = idx_q + 3'd1;
          tx_ld_byte = cfg_byte(idx_q + 3'd1, 32'(base_q), 32'(lenm1_q));
        end
      end
      S_CMD_DATA: if (tx_acc) state_d = mode_q ? S_RDBACK : S_PAYLOAD;
      S_PAYLOAD: begin
        if (src_acc) begin
          tx_ld = 1'b1; tx_ld_byte = src_data_i;
        end else if (tx_acc && cnt_zero) begin
          state_d = S_CMD_RUN; tx_ld = 1'b1; tx_ld_byte = CPU_RUN;
        end
      end
      S_CMD_RUN: if (tx_acc) state_d = S_DONE;
      S_RDBACK: begin
        if (cnt_zero)                          state_d = S_DONE;
        else if (!rx_acc && tmo_q == TMO_LAST) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pending tx byte; ready must go low then high again before the next byte is shown.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_byte_q <= 8'h00; tx_pend_q <= 1'b0; tx_armed_q <= 1'b1; tx_low_q <= 1'b0;
    end else begin
      if (tx_ld) begin
        tx_byte_q <= tx_ld_byte; tx_pend_q <= 1'b1;
      end else if (tx_acc) begin
        tx_pend_q <= 1'b0;
      end
      if (tx_acc) begin
        tx_armed_q <= 1'b0; tx_low_q <= 1'b0;
      end else if (!tx_armed_q) begin
        if (!tx_rdy_i)     tx_low_q <= 1'b1;
        else if (tx_low_q) tx_armed_q <= 1'b1;
      end
    end
  end

  // Request capture and the shared payload/readback byte counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_q <= 1'b0; base_q <= '0; lenm1_q <= '0; cnt_q <= '0; idx_q <= 3'd0;
    end else begin
      idx_q <= idx_d;
      if (state_q == S_IDLE && start_i) begin
        mode_q  <= mode_i;
        base_q  <= base_addr_i;
        lenm1_q <= len_i - XLEN'(1);
        cnt_q   <= len_i;
      end else if (src_acc || rd_take) begin
        cnt_q <= cnt_q - XLEN'(1);
      end
    end
  end

  // Readback capture and inter-byte timeout; rx is always drained once out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_rdy_q <= 1'b0; rd_vld_q <= 1'b0; rd_data_q <= 8'h00; tmo_q <= '0;
    end else begin
      rx_rdy_q <= 1'b1;
      rd_vld_q <= rd_take;
      if (rd_take) rd_data_q <= rx_data_i;
      if (state_q != S_RDBACK || rx_acc) tmo_q <= '0;
      else                               tmo_q <= tmo_q + TW'(1);
    end
  end

endmodule
